// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Shares the single register-file write port among NREQ writeback
//   requesters, such as ALU, load and link. Each requester has a valid/ready
//   handshake.
//   A round-robin arbiter grants at most one requester per cycle. The winning
//   address and data are captured into a registered output stage, which
//   drives the register file directly.
//   A pending-write mask is also exported for hazard logic.
//
// Configuration macro:
//   RF_ARB_FIXED_PRIO_EN
//     Defined:   fixed priority, and the lowest index wins. There is no
//                pointer register.
//     Undefined: round-robin. This is the default.
//
// Parameters:
//   NREQ   number of write requesters (2..4)
//   CNT_W  width of the issued-write counter
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]      requester i has a write pending
//   req_addr   [4*NREQ]    dest register of requester i, bits [4i+3:4i]
//   req_data   [32*NREQ]   write data of requester i, bits [32i+31:32i]
//   req_ready  [NREQ]      one-hot grant; a transfer happens on valid & ready
//   rf_hold    freeze the write port (pipeline stall)
//   rf_ld      register-file write enable
//   rf_bd      register-file destination select
//   rf_pc      register-file write data
//   pend_mask  one-hot of rf_bd while rf_ld is high, else 0
//   wr_count   number of writes issued since reset (wraps)
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rf_hold,
  output logic                 rf_ld,
  output logic [3:0]           rf_bd,
  output logic [31:0]          rf_pc,
  output logic [15:0]          pend_mask,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Per-requester views of the flattened address and data buses.
  logic [3:0]  addr_arr [NREQ];
  logic [31:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[4*gi +: 4];
      assign data_arr[gi] = req_data[32*gi +: 32];
    end
  endgenerate

  // Current search start point.
  logic [PTR_W-1:0] ptr_cur;

  // Arbitration results.
  logic [NREQ-1:0]  grant_vec;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic             xfer;
  logic [PTR_W:0]   cand;

  // Output stage registers.
  logic             rf_ld_reg;
  logic [3:0]       rf_bd_reg;
  logic [31:0]      rf_pc_reg;
  logic [CNT_W-1:0] wr_count_reg;

  // ---------------------------------------------------------------------------
  // Arbitration.
  // Search upward from the pointer, modulo NREQ, and pick the first valid
  // requester. The candidate index has one extra bit, so that
  // ptr + k cannot overflow before the wrap correction is applied.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_cur} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Grants are suppressed during a hold and while reset is asserted.
  // Because of this, a transfer is exactly "any grant bit set".
  always_comb begin
    grant_vec = '0;
    if (grant_found && !rf_hold && rst_n) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;
  assign xfer      = |grant_vec;

  // ---------------------------------------------------------------------------
  // Round-robin pointer. After a transfer, the pointer moves to the slot just
  // past the winner, so the winner gets the lowest priority next time.
  // ---------------------------------------------------------------------------
`ifdef RF_ARB_FIXED_PRIO_EN
  assign ptr_cur = '0;
`else
  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (xfer) begin
      if (grant_idx == PTR_W'(NREQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr_cur = ptr_reg;
`endif

  // ---------------------------------------------------------------------------
  // Output stage.
  // While rf_hold is high, everything freezes, including rf_ld, because the
  // register file is stalled by the same hold.
  // On an idle edge, only rf_ld drops. rf_bd and rf_pc keep their last value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ld_reg    <= 1'b0;
      rf_bd_reg    <= 4'd0;
      rf_pc_reg    <= 32'd0;
      wr_count_reg <= '0;
    end else if (!rf_hold) begin
      rf_ld_reg <= xfer;
      if (xfer) begin
        rf_bd_reg    <= addr_arr[grant_idx];
        rf_pc_reg    <= data_arr[grant_idx];
        wr_count_reg <= wr_count_reg + CNT_W'(1);
      end
    end
  end

  assign rf_ld    = rf_ld_reg;
  assign rf_bd    = rf_bd_reg;
  assign rf_pc    = rf_pc_reg;
  assign wr_count = wr_count_reg;

  // Pending-write mask: decode the in-flight destination.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pend
      assign pend_mask[gi] = rf_ld_reg && (rf_bd_reg == 4'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int NREQ  = 3;
  localparam int CNT_W = 4;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [4*NREQ-1:0]  req_addr;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rf_hold;
  logic               rf_ld;
  logic [3:0]         rf_bd;
  logic [31:0]        rf_pc;
  logic [15:0]        pend_mask;
  logic [CNT_W-1:0]   wr_count;

  int total;
  int bad;
  int exp_cnt;

  // Register-file model: captures on rising edges while rf_ld=1 and not stalled.
  logic [31:0] rf_model [16];

  rf_write_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_hold   (rf_hold),
    .rf_ld     (rf_ld),
    .rf_bd     (rf_bd),
    .rf_pc     (rf_pc),
    .pend_mask (pend_mask),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && rf_ld && !rf_hold) rf_model[rf_bd] <= rf_pc;
  end

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[4*i +: 4]   = a;
    req_data[32*i +: 32] = d;
  endtask

  // Pulse reset while inputs are idle; called just after a negedge.
  task automatic do_reset();
    req_valid = '0;
    rf_hold   = 1'b0;
    rst_n     = 1'b0;
    #1;
    rst_n     = 1'b1;
    exp_cnt   = 0;
  endtask

  task automatic test_reset();
    // Get a write in flight, then assert reset before the next edge.
    @(negedge clk);
    set_req(1, 4'd4, 32'd44);
    req_valid = 3'b010;
    @(negedge clk);
    total++; if (rf_ld !== 1'b1) begin bad++; $display("FAIL reset_pre_ld: got %0b want 1", rf_ld); end
    rst_n = 1'b0;
    #1;
    total++; if (rf_ld !== 1'b0) begin bad++; $display("FAIL reset_ld: got %0b want 0", rf_ld); end
    total++; if (rf_bd !== 4'd0) begin bad++; $display("FAIL reset_bd: got %0d want 0", rf_bd); end
    total++; if (rf_pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", rf_pc); end
    total++; if (pend_mask !== 16'h0) begin bad++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
    total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
    total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 0;
    $display("test_reset: in-flight write dropped by async reset");
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(1, 4'd10, 32'd99);
    req_valid = 3'b010;
    #1;
    total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", req_ready); end
    @(negedge clk);
    exp_cnt++;
    total++; if (rf_ld !== 1'b1) begin bad++; $display("FAIL single_ld: got %0b want 1", rf_ld); end
    total++; if (rf_bd !== 4'd10) begin bad++; $display("FAIL single_bd: got %0d want 10", rf_bd); end
    total++; if (rf_pc !== 32'd99) begin bad++; $display("FAIL single_pc: got %0d want 99", rf_pc); end
    total++; if (pend_mask !== 16'h0400) begin bad++; $display("FAIL single_pend: got %h want 0400", pend_mask); end
    total++; if (wr_count !== 4'(exp_cnt)) begin bad++; $display("FAIL single_cnt: got %0d want %0d", wr_count, exp_cnt); end
    req_valid = '0;
    @(negedge clk);
    total++; if (rf_model[10] !== 32'd99) begin bad++; $display("FAIL single_rf10: got %0d want 99", rf_model[10]); end
    total++; if (rf_ld !== 1'b0) begin bad++; $display("FAIL single_idle_ld: got %0b want 0", rf_ld); end
    total++; if (rf_bd !== 4'd10) begin bad++; $display("FAIL single_idle_bd: got %0d want 10", rf_bd); end
    total++; if (pend_mask !== 16'h0) begin bad++; $display("FAIL single_idle_pend: got %h want 0", pend_mask); end
    $display("test_single: req1 R10<=99");
  endtask

  task automatic test_round_robin();
    int order [6];
    logic [2:0] exp_rdy;
`ifdef RF_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif
    @(negedge clk);
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 32'(100 + i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_rdy = 3'b001 << order[k];
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      @(negedge clk);
      exp_cnt++;
      total++; if (rf_bd !== 4'(order[k] + 1)) begin bad++; $display("FAIL rr_bd[%0d]: got %0d want %0d", k, rf_bd, order[k] + 1); end
      total++; if (rf_pc !== 32'(100 + order[k])) begin bad++; $display("FAIL rr_pc[%0d]: got %0d want %0d", k, rf_pc, 100 + order[k]); end
      $display("test_round_robin: cycle %0d grant %0d", k, order[k]);
    end
    req_valid = '0;
    total++; if (wr_count !== 4'd6) begin bad++; $display("FAIL rr_cnt: got %0d want 6", wr_count); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    set_req(1, 4'd7, 32'd70);
    req_valid = 3'b010;
    @(negedge clk);
    exp_cnt++;
    total++; if (rf_ld !== 1'b1 || rf_bd !== 4'd7) begin bad++; $display("FAIL hold_pre: got ld=%0b bd=%0d want ld=1 bd=7", rf_ld, rf_bd); end
    set_req(0, 4'd12, 32'd120);
    req_valid = 3'b001;
    rf_hold   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 000", k, req_ready); end
      @(negedge clk);
      total++; if (rf_ld !== 1'b1 || rf_bd !== 4'd7 || rf_pc !== 32'd70) begin bad++; $display("FAIL hold_out[%0d]: got ld=%0b bd=%0d pc=%0d want 1/7/70", k, rf_ld, rf_bd, rf_pc); end
      total++; if (wr_count !== 4'(exp_cnt)) begin bad++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", k, wr_count, exp_cnt); end
    end
    rf_hold = 1'b0;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL hold_release_ready: got %b want 001", req_ready); end
    @(negedge clk);
    exp_cnt++;
    req_valid = '0;
    total++; if (rf_ld !== 1'b1 || rf_bd !== 4'd12 || rf_pc !== 32'd120) begin bad++; $display("FAIL hold_release_out: got ld=%0b bd=%0d pc=%0d want 1/12/120", rf_ld, rf_bd, rf_pc); end
    total++; if (wr_count !== 4'(exp_cnt)) begin bad++; $display("FAIL hold_release_cnt: got %0d want %0d", wr_count, exp_cnt); end
    total++; if (rf_model[7] !== 32'd70) begin bad++; $display("FAIL hold_rf7: got %0d want 70", rf_model[7]); end
    $display("test_hold: 3 stalled cycles, req0 granted after release");
  endtask

  task automatic test_same_dest();
    @(negedge clk);
    do_reset();
    set_req(0, 4'd5, 32'd7);
    set_req(2, 4'd5, 32'd8);
    req_valid = 3'b101;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL same_ready0: got %b want 001", req_ready); end
    @(negedge clk);
    total++; if (rf_bd !== 4'd5 || rf_pc !== 32'd7) begin bad++; $display("FAIL same_first: got bd=%0d pc=%0d want 5/7", rf_bd, rf_pc); end
    req_valid = 3'b100;
    #1;
    total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL same_ready2: got %b want 100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (rf_ld !== 1'b1 || rf_pc !== 32'd8) begin bad++; $display("FAIL same_second: got ld=%0b pc=%0d want 1/8", rf_ld, rf_pc); end
    @(negedge clk);
    total++; if (rf_model[5] !== 32'd8) begin bad++; $display("FAIL same_rf5: got %0d want 8", rf_model[5]); end
    total++; if (wr_count !== 4'd2) begin bad++; $display("FAIL same_cnt: got %0d want 2", wr_count); end
    $display("test_same_dest: R5 final value 8");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    do_reset();
    set_req(0, 4'd15, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 15) begin
        total++; if (wr_count !== 4'd15) begin bad++; $display("FAIL wrap_cnt15: got %0d want 15", wr_count); end
      end
      if (k == 16) begin
        total++; if (wr_count !== 4'd0) begin bad++; $display("FAIL wrap_cnt16: got %0d want 0", wr_count); end
      end
    end
    req_valid = '0;
    total++; if (wr_count !== 4'd1) begin bad++; $display("FAIL wrap_cnt17: got %0d want 1", wr_count); end
    total++; if (pend_mask !== 16'h8000) begin bad++; $display("FAIL wrap_pend15: got %h want 8000", pend_mask); end
    $display("test_wrap: 17 writes, wr_count=%0d", wr_count);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    rf_hold   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < 16; i++) rf_model[i] = 32'd0;
    #2;
    total++; if (rf_ld !== 1'b0 || rf_bd !== 4'd0 || rf_pc !== 32'd0) begin bad++; $display("FAIL init_out: got ld=%0b bd=%0d pc=%0d want 0/0/0", rf_ld, rf_bd, rf_pc); end
    total++; if (wr_count !== 4'd0 || pend_mask !== 16'h0) begin bad++; $display("FAIL init_cnt: got cnt=%0d pend=%h want 0/0", wr_count, pend_mask); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("init: reset state checked");

    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_same_dest();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
